div8_by_4_iter: RTL and testbench
=================================

DIV8_BY_4_ITER -- requirements
Module: div8_by_4_iter

Interface
REQ-001 SHALL have parameters: DW default 8, dividend/quotient width; VW default 4, divisor/remainder width.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: in_valid  input  1  operand request valid.
REQ-005 SHALL have ports: in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have ports: P  input  DW  dividend (product-width operand).
REQ-007 SHALL have ports: B  input  VW  divisor.
REQ-008 SHALL have ports: out_valid  output  1  result valid.
REQ-009 SHALL have ports: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports: Q  output  DW  quotient.
REQ-011 SHALL have ports: R  output  VW  remainder.
REQ-012 SHALL have ports: div_by_zero  output  1  result came from B==0.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL assert in_ready only in IDLE; acceptance = in_valid && in_ready on a rising edge.
REQ-015 SHALL on acceptance latch P and B, clear the partial remainder, load the iteration counter with DW-1, and go to BUSY.
REQ-016 SHALL in BUSY perform one restoring step per cycle: shift the remainder left by one bit, bringing in the next dividend MSB; subtract B when the (VW+1)-bit remainder >= B; shift the result bit into the quotient.
REQ-017 SHALL leave BUSY after exactly DW cycles (counter reaching 0) and enter DONE; out_valid rises the cycle after the last step, giving DW+1 cycles from acceptance edge to out_valid.
REQ-018 SHALL hold Q, R, div_by_zero and out_valid stable in DONE until out_valid && out_ready; then return to IDLE on that edge.
REQ-019 SHALL, with out_ready held high, allow a new acceptance on the cycle after the DONE->IDLE edge (throughput one result per DW+2 cycles).
REQ-020 SHALL for B==0 skip BUSY, go directly to DONE with Q = all ones, R = P[VW-1:0], div_by_zero = 1.
REQ-021 SHALL satisfy P == Q*B + R and R < B for every B != 0, arithmetic unsigned.
REQ-022 SHALL ignore in_valid outside IDLE; P and B may change freely after acceptance.
REQ-023 SHALL keep Q, R, div_by_zero driven from registers only; outputs are undefined-free but meaningful only while out_valid is high.

Reset
REQ-024 SHALL on rst_n low, asynchronously force: state IDLE, in_ready 1 (once released), out_valid 0, Q 0, R 0, div_by_zero 0, counter 0.
REQ-025 SHALL abort any BUSY or DONE operation on reset with no result delivered; the first operation after release starts from a clean state.

Structure
REQ-026 SHALL place DW/VW defaults and the state enumeration in shared package div_pkg.
REQ-027 SHALL instantiate one combinational sub-module div_step (remainder in, dividend bit in, divisor in -> next remainder, quotient bit) per iteration, reused every cycle.

Verification
REQ-028 SHALL check: P=0x8F, B=0x7, out_ready=1 -> out_valid 9 cycles after acceptance, Q=0x14, R=0x3, div_by_zero=0.
REQ-029 SHALL check: P=0xE1, B=0xF -> Q=0x0F, R=0x0; P=0x00, B=0x5 -> Q=0x00, R=0x0.
REQ-030 SHALL check: P=0x5A, B=0x0 -> out_valid the cycle after acceptance, Q=0xFF, R=0xA, div_by_zero=1.
REQ-031 SHALL check backpressure: out_ready low for 5 cycles in DONE -> Q/R/out_valid stable, in_ready low, in_valid pulses ignored; release -> IDLE next edge.
REQ-032 SHALL check reset mid-BUSY (after step 4) -> out_valid stays 0, in_ready 1 after release, next P=0xFF, B=0x3 gives Q=0x55, R=0x0.
REQ-033 SHALL run exhaustive random-order sweep of all 4096 (P,B) pairs with randomized out_ready, checking REQ-020/REQ-021.

Source files
------------

// File: rtl/div_pkg.sv
// Shared defaults and state encoding for the iterative restoring divider.
package div_pkg;
  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] rem,
  input  logic          dbit,
  input  logic [VW-1:0] b,
  output logic [VW-1:0] rem_nxt,
  output logic          q_bit
);
  logic [VW:0] trial;
  logic [VW:0] diff;

  assign trial = {rem, dbit};
  assign diff  = trial - {1'b0, b};
  assign q_bit = (trial >= {1'b0, b});
  // rem < b on entry, so trial < 2b and the difference always fits in VW bits
  assign rem_nxt = q_bit ? diff[VW-1:0] : trial[VW-1:0];
endmodule

// File: rtl/div8_by_4_iter.sv
// Iterative unsigned divider: DW-bit dividend by VW-bit divisor, one bit per cycle.
module div8_by_4_iter
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] P,
  input  logic [VW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          div_by_zero
);
  localparam int CW = cnt_w(DW);

  div_state_e    state, state_nxt;
  logic [DW-1:0] p_sh;
  logic [VW-1:0] b_r;
  logic [VW-1:0] rem_r;
  logic [DW-1:0] q_r;
  logic [CW-1:0] cnt;
  logic          dbz_r;
  logic [VW-1:0] rem_nxt;
  logic          q_bit;
  logic          accept;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign Q           = q_r;
  assign R           = rem_r;
  assign div_by_zero = dbz_r;

  div_step #(.VW(VW)) u_step (
    .rem     (rem_r),
    .dbit    (p_sh[DW-1]),
    .b       (b_r),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (B == '0) ? DONE : BUSY;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sh  <= '0;
      b_r   <= '0;
      rem_r <= '0;
      q_r   <= '0;
      cnt   <= '0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          p_sh <= P;
          b_r  <= B;
          cnt  <= CW'(DW - 1);
          // zero divisor short-circuits straight to a saturated result
          if (B == '0) begin
            q_r   <= '1;
            rem_r <= P[VW-1:0];
            dbz_r <= 1'b1;
          end else begin
            q_r   <= '0;
            rem_r <= '0;
            dbz_r <= 1'b0;
          end
        end
        BUSY: begin
          p_sh  <= {p_sh[DW-2:0], 1'b0};
          rem_r <= rem_nxt;
          q_r   <= {q_r[DW-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div8_by_4_iter.sv
// Directed vector table, handshake corner cases and an exhaustive shuffled sweep.
module tb_div8_by_4_iter;
  logic       clk = 0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [7:0] P, Q;
  logic [3:0] B, R;

  int checks = 0;
  int errors = 0;
  time last_acc_t;

  div8_by_4_iter #(.DW(8), .VW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with DUT idle; returns at posedge+1 after the result handshake.
  task automatic run_op(input logic [7:0] p, input logic [3:0] b, input int hold,
                        output logic [7:0] q, output logic [3:0] r, output logic dz,
                        output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    out_ready = (hold == 0);
    P = p; B = b; in_valid = 1'b1;
    @(posedge clk);
    last_acc_t = $time;
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    lat = out_valid ? n : -1;
    q = Q; r = R; dz = div_by_zero;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] q, q0;
    logic [3:0] r, r0;
    logic       dz, seen;
    int         lat, tmp, j;
    time        t0;
    int         order[4096];

    vecs[0] = '{8'h8F, 4'h7, 8'h14, 4'h3, 1'b0, 9};
    vecs[1] = '{8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0, 9};
    vecs[2] = '{8'h00, 4'h5, 8'h00, 4'h0, 1'b0, 9};
    vecs[3] = '{8'h5A, 4'h0, 8'hFF, 4'hA, 1'b1, 1};
    vecs[4] = '{8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 9};
    vecs[5] = '{8'h0F, 4'hF, 8'h01, 4'h0, 1'b0, 9};
    vecs[6] = '{8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 9};
    vecs[7] = '{8'h07, 4'h8, 8'h00, 4'h7, 1'b0, 9};
    vecs[8] = '{8'h64, 4'h9, 8'h0B, 4'h1, 1'b0, 9};
    vecs[9] = '{8'h00, 4'h0, 8'hFF, 4'h0, 1'b1, 1};

    rst_n = 0; in_valid = 0; out_ready = 1; P = 0; B = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_q", Q, 0);
    chk("rst_r", R, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].p, vecs[i].b, 0, q, r, dz, lat);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // back-to-back throughput: DW+2 cycles between acceptances
    run_op(8'h8F, 4'h7, 0, q, r, dz, lat);
    t0 = last_acc_t;
    run_op(8'h8F, 4'h7, 0, q, r, dz, lat);
    chk("throughput", 32'(last_acc_t - t0), 32'd100);

    // backpressure in DONE
    out_ready = 0;
    P = 8'h8F; B = 4'h7; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    j = 0;
    while (!out_valid && j < 20) begin @(posedge clk); #1; j++; end
    chk("bp_valid", out_valid, 1);
    q0 = Q; r0 = R;
    chk("bp_q0", q0, 8'h14);
    for (int i = 0; i < 5; i++) begin
      P = 8'h33; B = 4'h2; in_valid = 1;
      @(posedge clk); #1;
      chk("bp_q_stable", Q, q0);
      chk("bp_r_stable", R, r0);
      chk("bp_ov_stable", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_ov", out_valid, 0);

    // reset in the middle of BUSY
    P = 8'h8F; B = 4'h7; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_busy", in_ready, 0);
    rst_n = 0;
    #2;
    chk("midrst_ov", out_valid, 0);
    chk("midrst_q", Q, 0);
    chk("midrst_r", R, 0);
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; seen |= out_valid; end
    chk("midrst_no_result", seen, 0);
    run_op(8'hFF, 4'h3, 0, q, r, dz, lat);
    chk("midrst_next_q", q, 8'h55);
    chk("midrst_next_r", r, 4'h0);

    // exhaustive sweep in shuffled order with random result backpressure
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] sp;
      logic [3:0] sb;
      logic [15:0] recon;
      sp = order[i][11:4];
      sb = order[i][3:0];
      run_op(sp, sb, $urandom_range(2, 0), q, r, dz, lat);
      if (sb == 0) begin
        chk("sweep_z_q", q, 8'hFF);
        chk("sweep_z_r", r, sp[3:0]);
        chk("sweep_z_dbz", dz, 1);
      end else begin
        recon = 16'(q) * 16'(sb) + 16'(r);
        chk("sweep_recon", recon, 16'(sp));
        chk("sweep_r_lt_b", (r < sb), 1);
        chk("sweep_dbz", dz, 0);
      end
      chk("sweep_lat", lat, (sb == 0) ? 1 : 9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
